fsm_state_trace_tx: RTL and testbench
=====================================

// Module: fsm_state_trace_tx
// PURPOSE
//  Transmit side of the FSM observability link. Samples a DUT FSM's state/out pair every clock.
//  Each change becomes a timestamped trace record in a small FIFO.
//  Records are serialized as 2-byte frames over a valid/ready byte stream to the trace collector.
//  Sits beside the FSM under test (e.g. fsm_buggy) in demo/formal builds.
// PARAMETERS
//  STATE_W  2  width of observed state, 1..4
//  DEPTH    8  record FIFO depth, power of 2, >=2
//  TS_W     6  delta-timestamp width, <=6
// PORTS
//  clk        in   1        single clock, all logic on posedge
//  rst_n      in   1        asynchronous, active-low reset
//  state_i    in   STATE_W  observed FSM state
//  out_i      in   1        observed FSM output
//  trace_en   in   1        capture enable; transmitter drains FIFO regardless
//  tx_valid   out  1        byte available on tx_data
//  tx_ready   in   1        collector accepts byte when tx_valid&&tx_ready
//  tx_data    out  8        frame byte
//  tx_last    out  1        high on second byte of a frame
//  drop_cnt   out  8        records dropped on FIFO full, saturates at 255
//  ovf        out  1        sticky: a drop has occurred
//  ovf_clr    in   1        clears ovf and drop_cnt (1-cycle pulse)
// BEHAVIOUR
//  - Reset (rst_n=0, async): FIFO empty, tx FSM IDLE.
//    tx_valid=0, tx_data=0, tx_last=0, drop_cnt=0, ovf=0, delta=0, prev={0,0}, en_q=0.
//    Outputs drop immediately on rst_n fall, including mid-frame; a partial frame is discarded.
//  - Sampling: each cycle cur={out_i,state_i}; prev<=cur; en_q<=trace_en.
//  - Event, evaluated in cycle N, requires trace_en=1 and one of:
//    a) en_q=0 (first enabled cycle; record delta forced to 0), or
//    b) cur!=prev.
//  - Delta counter: increments every cycle, saturating at 2^TS_W-1.
//    Cleared to 0 on every event, whether recorded or dropped.
//    An event's record carries the counter value before clearing.
//  - Push: at end of cycle N if FIFO not full. Full is evaluated before any same-cycle pop.
//    Full + event (even with simultaneous pop) -> record dropped, drop_cnt+1 (sat), ovf<=1.
//    ovf_clr in the same cycle as a drop: the clear wins.
//  - Frame: byte0={1'b1,2'b00,out,state zero-extended to 4}.
//    byte1={2'b00,delta zero-extended to 6}, tx_last=1.
//  - TX FSM:
//    IDLE -(FIFO non-empty: pop into hold reg)-> BYTE0 -(accept)-> BYTE1 -(accept)-> IDLE.
//    BYTE1 accept with FIFO non-empty goes straight to BYTE0 with the next record (back-to-back frames).
//  - tx_valid=1 in BYTE0/BYTE1. tx_data/tx_last hold stable while tx_valid&&!tx_ready.
//  - Latency: event in cycle N with FIFO empty and FSM IDLE -> byte0 valid in cycle N+2.
//  - Steady throughput: 1 frame per 2 accepted cycles. Records leave in arrival order.
//  - trace_en falls: no further pushes; the FIFO drains completely.
// CONFIGURATION
//  FSM_TRACE_OVF_MARK_EN defined:
//   - After >=1 drop, the first time the FIFO has a free slot a marker record is pushed before any new event record.
//   - Marker frame: byte0=8'hFF, byte1={2'b00, min(drops since last marker,63)}.
//   - If an event occurs in the same cycle as the marker push, that event is dropped and counted toward the next marker.
//   - drop_cnt/ovf behave as below.
//  Not defined: no markers; drops visible only via drop_cnt/ovf.
// TESTING
//  1. Reset release, trace_en=1, state_i=2, out_i=0, tx_ready=1:
//     -> frame 8'h82, 8'h00 (delta 0), tx_last on byte1, byte0 in 2nd cycle after enable.
//  2. state 0->1 after 5 stable cycles, tx_ready=1 -> frame 8'h81, 8'h05.
//  3. tx_ready=0 for 10 cycles during byte0 -> tx_data=8'h81 held stable, no pop, frame completes after ready.
//  4. tx_ready=0, 10 state changes with DEPTH=8 -> 8 frames delivered in order, drop_cnt=2, ovf=1.
//     ovf_clr -> both 0. With FSM_TRACE_OVF_MARK_EN, marker 8'hFF,8'h02 appears after the 8 frames.
//  5. rst_n low while tx in BYTE1 -> tx_valid=0 same cycle, FIFO empty after release, no stale byte1.
//  6. No change for 100 cycles, then change -> delta byte 8'h3F (saturated); trace_en=0 changes produce no frames.

Source files
------------

// File: rtl/fsm_state_trace_tx.sv
// fsm_state_trace_tx: timestamps FSM state/out changes into a FIFO and streams them as 2-byte frames.
// Define FSM_TRACE_OVF_MARK_EN to insert an overflow marker frame after records are dropped.
module fsm_state_trace_tx #(
  parameter int STATE_W = 2,
  parameter int DEPTH   = 8,
  parameter int TS_W    = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [STATE_W-1:0] state_i,
  input  logic               out_i,
  input  logic               trace_en,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [7:0]         tx_data,
  output logic               tx_last,
  output logic [7:0]         drop_cnt,
  output logic               ovf,
  input  logic               ovf_clr
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, BYTE0, BYTE1} tx_st_e;
  tx_st_e st_q, st_d;
  logic [STATE_W:0] cur, prev_q;
  logic en_q, ev, full, empty, push, pop, drop;
  logic [TS_W-1:0] delta_q, delta_d;
  logic [15:0] mem [DEPTH];
  logic [15:0] hold_q, ev_rec, wdata;
  logic [AW:0] wr_q, rd_q;
  assign cur     = {out_i, state_i};
  assign ev      = trace_en && (!en_q || cur != prev_q);
  assign ev_rec  = {1'b1, 2'b00, out_i, 4'(state_i), 2'b00, 6'(en_q ? delta_q : '0)};
  assign delta_d = ev ? '0 : (&delta_q ? delta_q : delta_q + 1'b1);
  assign empty   = wr_q == rd_q;
  assign full    = wr_q[AW] != rd_q[AW] && wr_q[AW-1:0] == rd_q[AW-1:0];
  assign pop     = !empty && (st_q == IDLE || (st_q == BYTE1 && tx_ready));
`ifdef FSM_TRACE_OVF_MARK_EN
  logic [5:0] mk_q, mk_d;
  logic mark_push;
  // A marker claims the free slot; a coincident event is dropped and counted for the next marker.
  assign mark_push = mk_q != 6'd0 && !full;
  assign push      = mark_push || (ev && !full);
  assign wdata     = mark_push ? {8'hFF, 2'b00, mk_q} : ev_rec;
  assign drop      = ev && (full || mark_push);
  assign mk_d      = mark_push ? 6'(drop) : mk_q + 6'(drop && !(&mk_q));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mk_q <= '0;
    else mk_q <= mk_d;
`else
  assign push  = ev && !full;
  assign wdata = ev_rec;
  assign drop  = ev && full;
`endif
  always_comb begin
    st_d = st_q;
    st_d = (st_q == IDLE)  ? (empty ? IDLE : BYTE0) :
           (st_q == BYTE0) ? (tx_ready ? BYTE1 : BYTE0) :
           (tx_ready ? (empty ? IDLE : BYTE0) : BYTE1);
  end
  always_ff @(posedge clk)
    if (push) mem[wr_q[AW-1:0]] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q     <= IDLE;
      prev_q   <= '0;
      en_q     <= 1'b0;
      delta_q  <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      hold_q   <= '0;
      drop_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      st_q     <= st_d;
      prev_q   <= cur;
      en_q     <= trace_en;
      delta_q  <= delta_d;
      wr_q     <= wr_q + (AW+1)'(push);
      rd_q     <= rd_q + (AW+1)'(pop);
      hold_q   <= pop ? mem[rd_q[AW-1:0]] : hold_q;
      drop_cnt <= ovf_clr ? 8'd0 : (drop && drop_cnt != 8'hFF) ? drop_cnt + 8'd1 : drop_cnt;
      ovf      <= ovf_clr ? 1'b0 : (drop ? 1'b1 : ovf);
    end
  assign tx_valid = st_q != IDLE;
  assign tx_data  = (st_q == BYTE0) ? hold_q[15:8] : (st_q == BYTE1) ? hold_q[7:0] : 8'h00;
  assign tx_last  = st_q == BYTE1;
endmodule

// File: tb/tb_fsm_state_trace_tx.sv
// tb_fsm_state_trace_tx: directed scoreboard bench for the FSM trace transmitter.
module tb_fsm_state_trace_tx;
  logic clk = 1'b0, rst_n = 1'b0, out_i = 1'b0, trace_en = 1'b0, tx_ready = 1'b0, ovf_clr = 1'b0;
  logic [1:0] state_i = 2'd0;
  logic tx_valid, tx_last, ovf;
  logic [7:0] tx_data, drop_cnt;
  logic [8:0] exp_q [$];
  int checks = 0, errors = 0;

  fsm_state_trace_tx #(.STATE_W(2), .DEPTH(8), .TS_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .state_i(state_i), .out_i(out_i), .trace_en(trace_en),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
    .drop_cnt(drop_cnt), .ovf(ovf), .ovf_clr(ovf_clr));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_frame(input logic [7:0] b0, input logic [7:0] b1);
    exp_q.push_back({1'b0, b0});
    exp_q.push_back({1'b1, b1});
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
    chk(name, 16'(exp_q.size()), 16'd0);
  endtask

  // Monitor: every accepted byte must match the oldest expected byte.
  always @(negedge clk)
    if (rst_n && tx_valid && tx_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte got last=%b data=%h expected none", tx_last, tx_data);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({tx_last, tx_data} !== e) begin
          errors++;
          $display("FAIL frame_byte got last=%b data=%h expected last=%b data=%h", tx_last, tx_data, e[8], e[7:0]);
        end
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] seq [10];
    #1;
    chk("rst_valid", 16'(tx_valid), 16'd0);
    chk("rst_data", 16'(tx_data), 16'd0);
    chk("rst_last", 16'(tx_last), 16'd0);
    chk("rst_drop", 16'(drop_cnt), 16'd0);
    chk("rst_ovf", 16'(ovf), 16'd0);
    tick();
    tick();
    // Test 1: first enabled cycle, delta forced 0, byte0 two cycles later.
    rst_n = 1'b1; trace_en = 1'b1; state_i = 2'd2; tx_ready = 1'b1;
    exp_frame(8'h82, 8'h00);
    tick();
    chk("lat_n1_valid", 16'(tx_valid), 16'd0);
    tick();
    chk("lat_n2_valid", 16'(tx_valid), 16'd1);
    chk("lat_n2_data", 16'(tx_data), 16'h82);
    // Test 2+3: change carries delta 5; stall byte0 for 10 cycles.
    repeat (4) tick();
    state_i = 2'd1; tx_ready = 1'b0;
    exp_frame(8'h81, 8'h05);
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_hold", {7'd0, tx_valid, tx_data}, 16'h0181);
    end
    tx_ready = 1'b1;
    wait_drain("drain_t3");
    // Test 4: one held frame, then 10 changes into an 8-deep FIFO.
    repeat (70) tick();
    tx_ready = 1'b0; state_i = 2'd2;
    exp_frame(8'h82, 8'h3F);
    seq = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 10; i++) begin
      tick();
      state_i = seq[i];
      if (i < 8) exp_frame({6'b100000, seq[i]}, 8'h00);
    end
    tick();
    tick();
    chk("ovf_drop_cnt", 16'(drop_cnt), 16'd2);
    chk("ovf_flag", 16'(ovf), 16'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_drop_cnt", 16'(drop_cnt), 16'd0);
    chk("clr_ovf", 16'(ovf), 16'd0);
`ifdef FSM_TRACE_OVF_MARK_EN
    exp_frame(8'hFF, 8'h02);
`endif
    tx_ready = 1'b1;
    wait_drain("drain_t4");
    // Test 5: reset during byte1 discards the partial frame.
    tx_ready = 1'b0; state_i = 2'd1;
    for (int i = 0; i < 20 && !tx_valid; i++) tick();
    chk("t5_byte0_valid", 16'(tx_valid), 16'd1);
    exp_q.push_back({1'b0, 8'h81});
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("t5_in_byte1", 16'({tx_valid, tx_last}), 16'd3);
    #2;
    rst_n = 1'b0; trace_en = 1'b0;
    #1;
    chk("t5_async_valid", 16'(tx_valid), 16'd0);
    chk("t5_async_data", 16'(tx_data), 16'd0);
    chk("t5_async_last", 16'(tx_last), 16'd0);
    chk("t5_partial_consumed", 16'(exp_q.size()), 16'd0);
    tick();
    tick();
    rst_n = 1'b1; tx_ready = 1'b1;
    repeat (20) tick();
    chk("t5_no_stale", 16'(tx_valid), 16'd0);
    // Test 6: fresh enable, saturated delta, then disabled changes produce nothing.
    trace_en = 1'b1;
    exp_frame(8'h81, 8'h00);
    repeat (100) tick();
    state_i = 2'd2;
    exp_frame(8'h82, 8'h3F);
    tick();
    trace_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      state_i = 2'(i);
      out_i = ~out_i;
    end
    wait_drain("drain_t6");
    repeat (20) tick();
    chk("t6_idle_after_disable", 16'(tx_valid), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
